// File: rtl/fifo_cal_reg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_cal_reg
//  Description : State register and head/tail/count datapath for an 8-entry
//                FIFO; drives memory strobes/addresses and status flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_cal_reg #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    next_state,
    output logic [2:0]    state,
    output logic [CW-1:0] data_count,
    output logic [AW-1:0] head,
    output logic [AW-1:0] tail,
    output logic          we,
    output logic          re,
    output logic [AW-1:0] wr_addr,
    output logic [AW-1:0] rd_addr,
    output logic          full,
    output logic          empty,
    output logic          wr_ack,
    output logic          wr_err,
    output logic          rd_ack,
    output logic          rd_err
);

    localparam logic [2:0]    c_IDLE     = 3'b000;
    localparam logic [2:0]    c_WRITE    = 3'b001;
    localparam logic [2:0]    c_READ     = 3'b010;
    localparam logic [2:0]    c_WR_ERROR = 3'b011;
    localparam logic [2:0]    c_RD_ERROR = 3'b100;
    localparam logic [CW-1:0] c_FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] c_ONE_CNT  = CW'(1);
    localparam logic [AW-1:0] c_ONE_PTR  = AW'(1);

    logic [2:0]    r_state;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic          r_full;
    logic          r_empty;
    logic          r_wr_ack;
    logic          r_wr_err;
    logic          r_rd_ack;
    logic          r_rd_err;

    logic [2:0]    w_ns_legal;
    logic [2:0]    w_eff_ns;
    logic [CW-1:0] w_count_nxt;

    // Unused encodings collapse to IDLE before the overflow/underflow guards.
    always_comb begin
        w_ns_legal = (next_state > c_RD_ERROR) ? c_IDLE : next_state;
        w_eff_ns   = w_ns_legal;
        if (w_ns_legal == c_WRITE && r_count == c_FULL_CNT)
            w_eff_ns = c_WR_ERROR;
        else if (w_ns_legal == c_READ && r_count == '0)
            w_eff_ns = c_RD_ERROR;
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_eff_ns == c_WRITE)
            w_count_nxt = r_count + c_ONE_CNT;
        else if (w_eff_ns == c_READ)
            w_count_nxt = r_count - c_ONE_CNT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_count  <= '0;
            r_head   <= '0;
            r_tail   <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_wr_ack <= 1'b0;
            r_wr_err <= 1'b0;
            r_rd_ack <= 1'b0;
            r_rd_err <= 1'b0;
        end else begin
            r_state  <= w_eff_ns;
            r_count  <= w_count_nxt;
            // Flags derive from the next count so they never trail data_count.
            r_full   <= (w_count_nxt == c_FULL_CNT);
            r_empty  <= (w_count_nxt == '0);
            r_wr_ack <= (w_eff_ns == c_WRITE);
            r_wr_err <= (w_eff_ns == c_WR_ERROR);
            r_rd_ack <= (w_eff_ns == c_READ);
            r_rd_err <= (w_eff_ns == c_RD_ERROR);
            if (w_eff_ns == c_WRITE)
                r_tail <= r_tail + c_ONE_PTR;
            if (w_eff_ns == c_READ)
                r_head <= r_head + c_ONE_PTR;
        end
    end

    assign we         = (w_eff_ns == c_WRITE) & ~rst;
    assign re         = (w_eff_ns == c_READ) & ~rst;
    assign wr_addr    = r_tail;
    assign rd_addr    = r_head;
    assign state      = r_state;
    assign data_count = r_count;
    assign head       = r_head;
    assign tail       = r_tail;
    assign full       = r_full;
    assign empty      = r_empty;
    assign wr_ack     = r_wr_ack;
    assign wr_err     = r_wr_err;
    assign rd_ack     = r_rd_ack;
    assign rd_err     = r_rd_err;

endmodule
`default_nettype wire

// File: tb/tb_fifo_cal_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_cal_reg
//  Description : Self-checking bench for fifo_cal_reg: reference model with
//                scoreboard queue plus a directed vector table.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_cal_reg;

    localparam logic [2:0] c_IDLE     = 3'b000;
    localparam logic [2:0] c_WRITE    = 3'b001;
    localparam logic [2:0] c_READ     = 3'b010;
    localparam logic [2:0] c_WR_ERROR = 3'b011;
    localparam logic [2:0] c_RD_ERROR = 3'b100;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] next_state;
    logic [2:0] state;
    logic [3:0] data_count;
    logic [2:0] head, tail, wr_addr, rd_addr;
    logic       we, re, full, empty, wr_ack, wr_err, rd_ack, rd_err;

    fifo_cal_reg #(.DEPTH(8), .AW(3), .CW(4)) dut (
        .clk(clk), .rst(rst), .next_state(next_state), .state(state),
        .data_count(data_count), .head(head), .tail(tail), .we(we), .re(re),
        .wr_addr(wr_addr), .rd_addr(rd_addr), .full(full), .empty(empty),
        .wr_ack(wr_ack), .wr_err(wr_err), .rd_ack(rd_ack), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] st;
        int         cnt;
        int         hd;
        int         tl;
        logic [3:0] flg;   // {wr_ack, wr_err, rd_ack, rd_err}
    } exp_t;

    typedef struct {
        logic [2:0] ns;
        logic [2:0] st;
        int         cnt;
        int         hd;
        int         tl;
        logic [3:0] flg;
    } vec_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   m_head = 0, m_tail = 0, m_count = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_regs(input string tag, input exp_t e);
        check({tag, ".state"}, int'(state), int'(e.st));
        check({tag, ".count"}, int'(data_count), e.cnt);
        check({tag, ".head"}, int'(head), e.hd);
        check({tag, ".tail"}, int'(tail), e.tl);
        check({tag, ".full"}, int'(full), int'(e.cnt == 8));
        check({tag, ".empty"}, int'(empty), int'(e.cnt == 0));
        check({tag, ".flags"}, int'({wr_ack, wr_err, rd_ack, rd_err}), int'(e.flg));
        if (int'(tail) == int'(head))
            check({tag, ".invariant"}, int'(data_count), full ? 8 : 0);
        else
            check({tag, ".invariant"}, int'(data_count), (int'(tail) - int'(head) + 8) % 8);
    endtask

    // One cycle: check 0-latency strobes, push expected registered state, compare after edge.
    task automatic step(input logic [2:0] ns);
        logic [2:0] leg, eff;
        exp_t e;
        @(negedge clk);
        next_state = ns;
        #1;
        leg = (ns > c_RD_ERROR) ? c_IDLE : ns;
        if (leg == c_WRITE && m_count == 8)     eff = c_WR_ERROR;
        else if (leg == c_READ && m_count == 0) eff = c_RD_ERROR;
        else                                    eff = leg;
        check("we", int'(we), int'(eff == c_WRITE));
        check("re", int'(re), int'(eff == c_READ));
        if (eff == c_WRITE) check("wr_addr", int'(wr_addr), m_tail);
        if (eff == c_READ)  check("rd_addr", int'(rd_addr), m_head);
        if (eff == c_WRITE) begin m_tail = (m_tail + 1) % 8; m_count++; end
        if (eff == c_READ)  begin m_head = (m_head + 1) % 8; m_count--; end
        e.st  = eff;
        e.cnt = m_count;
        e.hd  = m_head;
        e.tl  = m_tail;
        e.flg = {eff == c_WRITE, eff == c_WR_ERROR, eff == c_READ, eff == c_RD_ERROR};
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            check_regs("sb", e);
        end
    endtask

    task automatic do_reset(input int cycles);
        exp_t e;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            rst = 1'b1;
            next_state = c_WRITE;
            #1;
            check("rst.we", int'(we), 0);
            check("rst.re", int'(re), 0);
        end
        @(posedge clk);
        #1;
        m_head = 0; m_tail = 0; m_count = 0;
        e.st = c_IDLE; e.cnt = 0; e.hd = 0; e.tl = 0; e.flg = 4'b0000;
        check_regs("reset", e);
        @(negedge clk);
        rst = 1'b0;
        next_state = c_IDLE;
    endtask

    vec_t vt[8];

    initial begin
        rst = 1'b1;
        next_state = c_IDLE;
        vt[0] = '{c_READ,     c_RD_ERROR, 0, 0, 0, 4'b0001};
        vt[1] = '{c_WRITE,    c_WRITE,    1, 0, 1, 4'b1000};
        vt[2] = '{c_WRITE,    c_WRITE,    2, 0, 2, 4'b1000};
        vt[3] = '{3'b111,     c_IDLE,     2, 0, 2, 4'b0000};
        vt[4] = '{c_READ,     c_READ,     1, 1, 2, 4'b0010};
        vt[5] = '{c_WR_ERROR, c_WR_ERROR, 1, 1, 2, 4'b0100};
        vt[6] = '{c_RD_ERROR, c_RD_ERROR, 1, 1, 2, 4'b0001};
        vt[7] = '{c_IDLE,     c_IDLE,     1, 1, 2, 4'b0000};

        do_reset(2);

        // Directed table from a freshly reset FIFO.
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            step(vt[i].ns);
            e.st = vt[i].st; e.cnt = vt[i].cnt; e.hd = vt[i].hd;
            e.tl = vt[i].tl; e.flg = vt[i].flg;
            check_regs($sformatf("vec%0d", i), e);
        end

        // Fill from empty, then overflow.
        do_reset(1);
        for (int i = 0; i < 8; i++) step(c_WRITE);
        check("fill.count", int'(data_count), 8);
        check("fill.full", int'(full), 1);
        check("fill.tail", int'(tail), 0);
        step(c_WRITE);
        check("ovf.state", int'(state), 3);
        check("ovf.wr_err", int'(wr_err), 1);
        check("ovf.count", int'(data_count), 8);

        // Drain and underflow.
        for (int i = 0; i < 8; i++) step(c_READ);
        check("drain.empty", int'(empty), 1);
        step(c_READ);
        check("udf.state", int'(state), 4);
        check("udf.rd_err", int'(rd_err), 1);

        // Wrap: write 6, read 6, write 4.
        do_reset(1);
        for (int i = 0; i < 6; i++) step(c_WRITE);
        for (int i = 0; i < 6; i++) step(c_READ);
        for (int i = 0; i < 4; i++) step(c_WRITE);
        check("wrap.tail", int'(tail), 2);
        check("wrap.head", int'(head), 6);
        check("wrap.count", int'(data_count), 4);

        // Illegal code with count=3.
        step(c_READ);
        step(3'b110);
        check("ill.state", int'(state), 0);
        check("ill.count", int'(data_count), 3);
        check("ill.head", int'(head), 7);
        check("ill.tail", int'(tail), 2);

        // Reset mid-traffic at count=5.
        step(c_WRITE);
        step(c_WRITE);
        check("pre_rst.count", int'(data_count), 5);
        do_reset(2);
        step(c_IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
